// File: rtl/rr_grant_enc4.sv
// Four-requester round-robin arbiter that feeds a 2-to-4 enable decoder.
// It grants one requester at a time and holds the grant until the owner
// asserts done, drops its request, or reaches the hold limit. Every grant
// is followed by at least one idle (en=0) guard cycle.
module rr_grant_enc4 #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [1:0] w_o,
  output logic       en_o,
  output logic       timeout_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // The hold limit is compared against a CNT_W-bit counter.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q;
  logic [1:0]       last_q;
  logic [1:0]       w_q;
  logic             en_q;
  logic             timeout_q;
  logic [CNT_W-1:0] hold_q;

  logic [1:0] winner_d;
  logic       any_req;
  logic       owner_req;
  logic       at_limit;
  logic       grant_exit;
  logic [3:0] rot_req;

  // Rotate the request vector so bit gi holds requester (last+1+gi) mod 4;
  // bit 0 is then the highest-priority candidate.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    logic [1:0] src_idx;
    assign src_idx     = last_q + 2'(gi + 1);
    assign rot_req[gi] = req_i[src_idx];
  end

  // Pick the first set bit of the rotated vector and map it back to an index.
  always_comb begin
    winner_d = last_q;
    if (rot_req[0])      winner_d = last_q + 2'd1;
    else if (rot_req[1]) winner_d = last_q + 2'd2;
    else if (rot_req[2]) winner_d = last_q + 2'd3;
    else if (rot_req[3]) winner_d = last_q;
  end

  assign any_req    = |req_i;
  assign owner_req  = req_i[w_q];
  assign at_limit   = (hold_q == HOLD_LAST);
  assign grant_exit = done_i || !owner_req || at_limit;

  // Arbitration state machine with registered grant outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      w_q       <= 2'd0;
      en_q      <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Done is meaningless without an owner; W keeps its last value.
          if (any_req) begin
            w_q     <= winner_d;
            en_q    <= 1'b1;
            hold_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (grant_exit) begin
            en_q      <= 1'b0;
            last_q    <= w_q;
            state_q   <= IDLE;
            // Only a pure hold-limit expiry counts as a timeout.
            timeout_q <= at_limit && !done_i && owner_req;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign w_o       = w_q;
  assign en_o      = en_q;
  assign timeout_o = timeout_q;

endmodule
